// File: rtl/draw_sprite_sheet.sv
// draw_sprite_sheet
//
// Sprite-sheet renderer for the VGA pixel path. It maps the current scan position onto a
// word address in an external sprite ROM that holds NUM_IMG equally sized images back to
// back. It then returns the fetched colour together with a per-pixel hit flag for the
// compositor. Image changes requested mid-frame are held in a pending register and only
// become active at a frame boundary, which prevents tearing. Optional 2x scaling and
// frame-counted blinking are provided.
//
// Pipeline (one pixel per cycle, no stalls):
//   edge 1  stage 1: window test, source coordinates, image index
//   edge 2  stage 2: rom_addr registered (ROM samples it on the next edge)
//   edge 3  ROM data valid; inside flag delayed to line up with rom_q
//   edge 4  stage 3: out_hit / out_data registered
// The result appears three edges after the edge that samples x_pos/y_pos.
//
// Ports:
//   vga_clk        pixel clock (sole clock)
//   reset          synchronous, active-high
//   x_pos, y_pos   current scan column / row
//   origin_x/y     sprite top-left corner on screen
//   img_sel        requested image index
//   img_sel_valid  one-cycle strobe loading img_sel into the pending register
//   frame_start    one-cycle strobe at the first pixel of a frame
//   scale2x        draw each source pixel as a 2x2 block
//   blink_en       enable periodic hiding
//   rom_addr       address to the sprite ROM (1-cycle registered read)
//   rom_q          ROM data, valid the cycle after rom_addr
//   out_data       pixel colour, 0 when not hit
//   out_hit        sprite is opaque at this pixel

module draw_sprite_sheet #(
    parameter int unsigned          IMG_W        = 92,
    parameter int unsigned          IMG_H        = 42,
    parameter int unsigned          NUM_IMG      = 3,
    parameter int unsigned          ADDR_W       = 14,
    parameter int unsigned          DATA_W       = 24,
    parameter logic [DATA_W-1:0]    TRANSP       = 24'hFF00FF,
    parameter int unsigned          BLINK_FRAMES = 16,
    // Derived widths; not meant to be overridden.
    parameter int unsigned          SEL_W        = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1,
    parameter int unsigned          BCNT_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        x_pos,
    input  logic [9:0]        y_pos,
    input  logic [9:0]        origin_x,
    input  logic [9:0]        origin_y,
    input  logic [SEL_W-1:0]  img_sel,
    input  logic              img_sel_valid,
    input  logic              frame_start,
    input  logic              scale2x,
    input  logic              blink_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_hit
);

    // Window sizes, one-to-one and doubled.
    localparam logic [10:0] W_NORM = 11'(IMG_W);
    localparam logic [10:0] H_NORM = 11'(IMG_H);
    localparam logic [10:0] W_DBL  = 11'(2 * IMG_W);
    localparam logic [10:0] H_DBL  = 11'(2 * IMG_H);

    // Constant multipliers for the address computation.
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] IMG_SIZE   = ADDR_W'(IMG_W * IMG_H);

    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BLINK_FRAMES - 1);

    // ------------------------------------------------------------------
    // Image select: pending / active
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] pending;
    logic [SEL_W-1:0] active;
    logic             sel_ok;
    logic [SEL_W-1:0] pending_next;
    logic [SEL_W-1:0] active_next;

    always_comb begin
        sel_ok       = img_sel_valid && (32'(img_sel) < NUM_IMG);
        pending_next = sel_ok ? img_sel : pending;
        // A frame_start in the same cycle as a valid strobe takes the new index directly,
        // and the pixel sampled in this cycle already uses it.
        active_next  = frame_start ? pending_next : active;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pending <= '0;
            active  <= '0;
        end else begin
            pending <= pending_next;
            active  <= active_next;
        end
    end

    // ------------------------------------------------------------------
    // Blink control
    // ------------------------------------------------------------------
    logic [BCNT_W-1:0] bcnt;
    logic              visible;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            bcnt    <= '0;
            visible <= 1'b1;
        end else if (!blink_en) begin
            bcnt    <= '0;
            visible <= 1'b1;
        end else if (frame_start) begin
            if (bcnt == BCNT_MAX) begin
                bcnt    <= '0;
                visible <= ~visible;
            end else begin
                bcnt <= bcnt + BCNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: window test and source coordinates
    // ------------------------------------------------------------------
    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] w_eff;
    logic [10:0] h_eff;
    logic        in_win;
    logic [9:0]  sx_next;
    logic [9:0]  sy_next;

    always_comb begin
        // Bit 10 is the borrow: sprite origin lies right of / below the scan position.
        dx     = {1'b0, x_pos} - {1'b0, origin_x};
        dy     = {1'b0, y_pos} - {1'b0, origin_y};
        w_eff  = scale2x ? W_DBL : W_NORM;
        h_eff  = scale2x ? H_DBL : H_NORM;
        in_win = !dx[10] && !dy[10] && ({1'b0, dx[9:0]} < w_eff) && ({1'b0, dy[9:0]} < h_eff);
        sx_next = scale2x ? {1'b0, dx[9:1]} : dx[9:0];
        sy_next = scale2x ? {1'b0, dy[9:1]} : dy[9:0];
    end

    logic             inside_s1;
    logic [9:0]       sx_s1;
    logic [9:0]       sy_s1;
    logic [SEL_W-1:0] img_s1;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            inside_s1 <= 1'b0;
            sx_s1     <= '0;
            sy_s1     <= '0;
            img_s1    <= '0;
        end else begin
            inside_s1 <= in_win;
            sx_s1     <= sx_next;
            sy_s1     <= sy_next;
            img_s1    <= active_next;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: ROM address
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_next;
    logic              inside_d1;
    logic              inside_d2;

    always_comb begin
        addr_next = ADDR_W'(img_s1) * IMG_SIZE + ADDR_W'(sy_s1) * ROW_STRIDE + ADDR_W'(sx_s1);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_addr  <= '0;
            inside_d1 <= 1'b0;
            inside_d2 <= 1'b0;
        end else begin
            rom_addr  <= inside_s1 ? addr_next : '0;
            inside_d1 <= inside_s1;
            // Extra delay matches the registered ROM read so inside_d2 lines up with rom_q.
            inside_d2 <= inside_d1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: colour key and output register
    // ------------------------------------------------------------------
    logic out_hit_next;

    always_comb begin
        out_hit_next = inside_d2 && visible && (rom_q != TRANSP);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            out_hit  <= 1'b0;
            out_data <= '0;
        end else begin
            out_hit  <= out_hit_next;
            out_data <= out_hit_next ? rom_q : '0;
        end
    end

endmodule

// File: tb/tb_draw_sprite_sheet.sv
module tb_draw_sprite_sheet;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  x_pos, y_pos, origin_x, origin_y;
    logic [1:0]  img_sel;
    logic        img_sel_valid, frame_start, scale2x, blink_en;
    logic [13:0] rom_addr;
    logic [23:0] rom_q;
    logic [23:0] out_data;
    logic        out_hit;

    int total = 0;
    int bad   = 0;

    always #5 vga_clk = ~vga_clk;

    draw_sprite_sheet dut (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .origin_x     (origin_x),
        .origin_y     (origin_y),
        .img_sel      (img_sel),
        .img_sel_valid(img_sel_valid),
        .frame_start  (frame_start),
        .scale2x      (scale2x),
        .blink_en     (blink_en),
        .rom_addr     (rom_addr),
        .rom_q        (rom_q),
        .out_data     (out_data),
        .out_hit      (out_hit)
    );

    // Sprite ROM model: word = address, except two keyed words used by the colour-key test.
    always @(posedge vga_clk) begin
        if (rom_addr == 14'd930)      rom_q <= 24'hFF00FF;
        else if (rom_addr == 14'd931) rom_q <= 24'h123456;
        else                          rom_q <= {10'd0, rom_addr};
    end

    // Present one pixel and hold it; return the address seen after the stage-2 edge and the
    // output seen after the stage-3 edge.
    task automatic pix(input int x, input int y,
                       output logic [13:0] a, output logic [23:0] d, output logic h);
        @(negedge vga_clk);
        x_pos = 10'(x);
        y_pos = 10'(y);
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1 a = rom_addr;
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1 d = out_data;
        h = out_hit;
    endtask

    task automatic frame_pulse();
        @(negedge vga_clk);
        frame_start = 1'b1;
        @(negedge vga_clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        x_pos = 10'd100; y_pos = 10'd50; origin_x = 10'd100; origin_y = 10'd50;
        img_sel = 2'd0; img_sel_valid = 1'b0; frame_start = 1'b0;
        scale2x = 1'b0; blink_en = 1'b0;
        repeat (3) @(posedge vga_clk);
        #1;
        total++;
        if (out_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%0b want=0", out_hit); end
        total++;
        if (out_data !== 24'd0) begin bad++; $display("FAIL reset_data got=%0h want=0", out_data); end
        total++;
        if (rom_addr !== 14'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", rom_addr); end
        @(negedge vga_clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [13:0] a; logic [23:0] d; logic h;
        pix(100, 50, a, d, h);
        total++;
        if (a !== 14'd0) begin bad++; $display("FAIL basic_tl_addr got=%0d want=0", a); end
        total++;
        if (h !== 1'b1 || d !== 24'd0) begin
            bad++; $display("FAIL basic_tl_out got=%0b/%0d want=1/0", h, d);
        end
        pix(191, 91, a, d, h);
        total++;
        if (a !== 14'd3863) begin bad++; $display("FAIL basic_br_addr got=%0d want=3863", a); end
        total++;
        if (h !== 1'b1 || d !== 24'd3863) begin
            bad++; $display("FAIL basic_br_out got=%0b/%0d want=1/3863", h, d);
        end
    endtask

    task automatic test_bounds();
        logic [13:0] a; logic [23:0] d; logic h;
        int xs [4] = '{99, 192, 191, 100};
        int ys [4] = '{50, 50, 92, 49};
        for (int i = 0; i < 4; i++) begin
            pix(xs[i], ys[i], a, d, h);
            total++;
            if (a !== 14'd0 || h !== 1'b0 || d !== 24'd0) begin
                bad++;
                $display("FAIL bounds_%0d (%0d,%0d) got addr=%0d hit=%0b data=%0d want 0/0/0",
                         i, xs[i], ys[i], a, h, d);
            end
        end
    endtask

    task automatic test_transp();
        logic [13:0] a; logic [23:0] d; logic h;
        pix(110, 60, a, d, h);
        total++;
        if (a !== 14'd930 || h !== 1'b0 || d !== 24'd0) begin
            bad++; $display("FAIL transp_key got addr=%0d hit=%0b data=%0h want 930/0/0", a, h, d);
        end
        pix(111, 60, a, d, h);
        total++;
        if (h !== 1'b1 || d !== 24'h123456) begin
            bad++; $display("FAIL transp_opaque got hit=%0b data=%0h want 1/123456", h, d);
        end
    endtask

    task automatic test_scale();
        logic [13:0] a; logic [23:0] d; logic h;
        @(negedge vga_clk);
        scale2x = 1'b1; origin_x = 10'd0; origin_y = 10'd0;
        pix(1, 1, a, d, h);
        total++;
        if (a !== 14'd0 || h !== 1'b1) begin
            bad++; $display("FAIL scale_11 got addr=%0d hit=%0b want 0/1", a, h);
        end
        pix(0, 0, a, d, h);
        total++;
        if (a !== 14'd0 || h !== 1'b1) begin
            bad++; $display("FAIL scale_00 got addr=%0d hit=%0b want 0/1", a, h);
        end
        pix(183, 83, a, d, h);
        total++;
        if (a !== 14'd3863 || d !== 24'd3863) begin
            bad++; $display("FAIL scale_br got addr=%0d data=%0d want 3863/3863", a, d);
        end
        pix(184, 0, a, d, h);
        total++;
        if (h !== 1'b0 || d !== 24'd0) begin
            bad++; $display("FAIL scale_out got hit=%0b data=%0d want 0/0", h, d);
        end
        @(negedge vga_clk);
        scale2x = 1'b0; origin_x = 10'd100; origin_y = 10'd50;
    endtask

    task automatic test_back_to_back();
        y_pos = 10'd50;
        for (int i = 0; i < 8; i++) begin
            @(negedge vga_clk);
            x_pos = 10'(100 + i);
            @(posedge vga_clk);
            #1;
            if (i >= 3) begin
                total++;
                if (out_hit !== 1'b1 || out_data !== 24'(i - 3)) begin
                    bad++;
                    $display("FAIL b2b_%0d got hit=%0b data=%0d want 1/%0d", i, out_hit,
                             out_data, i - 3);
                end
            end
        end
    endtask

    task automatic test_img_sel();
        logic [13:0] a; logic [23:0] d; logic h;
        @(negedge vga_clk);
        img_sel = 2'd2; img_sel_valid = 1'b1;
        @(negedge vga_clk);
        img_sel_valid = 1'b0;
        pix(100, 50, a, d, h);
        total++;
        if (a !== 14'd0) begin bad++; $display("FAIL img_pending got=%0d want=0", a); end
        frame_pulse();
        pix(100, 50, a, d, h);
        total++;
        if (a !== 14'd7728 || d !== 24'd7728 || h !== 1'b1) begin
            bad++; $display("FAIL img_active got addr=%0d data=%0d hit=%0b want 7728/7728/1", a, d, h);
        end
        @(negedge vga_clk);
        img_sel = 2'd3; img_sel_valid = 1'b1;
        @(negedge vga_clk);
        img_sel_valid = 1'b0;
        frame_pulse();
        pix(100, 50, a, d, h);
        total++;
        if (a !== 14'd7728) begin bad++; $display("FAIL img_oor got=%0d want=7728", a); end
        // Strobe and frame_start together: the pixel of that very cycle uses image 1.
        @(negedge vga_clk);
        img_sel = 2'd1; img_sel_valid = 1'b1; frame_start = 1'b1;
        x_pos = 10'd100; y_pos = 10'd50;
        @(posedge vga_clk);
        @(negedge vga_clk);
        img_sel_valid = 1'b0; frame_start = 1'b0;
        @(posedge vga_clk);
        #1;
        total++;
        if (rom_addr !== 14'd3864) begin
            bad++; $display("FAIL img_same_cycle got=%0d want=3864", rom_addr);
        end
    endtask

    task automatic test_blink();
        logic [13:0] a; logic [23:0] d; logic h;
        @(negedge vga_clk);
        blink_en = 1'b1;
        repeat (15) frame_pulse();
        pix(100, 50, a, d, h);
        total++;
        if (h !== 1'b1) begin bad++; $display("FAIL blink_15 got hit=%0b want=1", h); end
        frame_pulse();
        pix(100, 50, a, d, h);
        total++;
        if (h !== 1'b0 || d !== 24'd0) begin
            bad++; $display("FAIL blink_16 got hit=%0b data=%0d want 0/0", h, d);
        end
        repeat (16) frame_pulse();
        pix(100, 50, a, d, h);
        total++;
        if (h !== 1'b1 || d !== 24'd3864) begin
            bad++; $display("FAIL blink_32 got hit=%0b data=%0d want 1/3864", h, d);
        end
        repeat (16) frame_pulse();
        pix(100, 50, a, d, h);
        total++;
        if (h !== 1'b0) begin bad++; $display("FAIL blink_48 got hit=%0b want=0", h); end
        @(negedge vga_clk);
        blink_en = 1'b0;
        pix(100, 50, a, d, h);
        total++;
        if (h !== 1'b1) begin bad++; $display("FAIL blink_off got hit=%0b want=1", h); end
    endtask

    task automatic test_reset_midflight();
        @(negedge vga_clk);
        x_pos = 10'd100; y_pos = 10'd50;
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        reset = 1'b1;
        x_pos = 10'd101;
        @(posedge vga_clk);
        #1;
        total++;
        if (out_hit !== 1'b0 || out_data !== 24'd0 || rom_addr !== 14'd0) begin
            bad++; $display("FAIL mid_reset got hit=%0b data=%0d addr=%0d want 0/0/0",
                            out_hit, out_data, rom_addr);
        end
        @(negedge vga_clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge vga_clk);
            #1;
            total++;
            if (i < 3 && (out_hit !== 1'b0 || out_data !== 24'd0)) begin
                bad++; $display("FAIL mid_flush_%0d got hit=%0b data=%0d want 0/0", i, out_hit, out_data);
            end else if (i == 3 && (out_hit !== 1'b1 || out_data !== 24'd1)) begin
                bad++; $display("FAIL mid_first got hit=%0b data=%0d want 1/1", out_hit, out_data);
            end
            if (i == 1) begin
                total++;
                if (rom_addr !== 14'd1) begin
                    bad++; $display("FAIL mid_active got addr=%0d want=1", rom_addr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounds();
        test_transp();
        test_scale();
        test_back_to_back();
        test_img_sel();
        test_blink();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_sprite_sheet.md
# draw_sprite_sheet

Pipelined, parametrised sprite-sheet renderer for the VGA pixel path. It turns the current scan coordinate into a sprite-memory address for one of `NUM_IMG` equally sized images stacked in a single ROM. It also returns the fetched colour with a per-pixel hit flag that the screen compositor uses to overlay the sprite. Image changes are latched at frame boundaries to prevent tearing, and the block adds 2x scaling and frame-counted blinking.

## Interface
- `IMG_W`, 92, image width in pixels
- `IMG_H`, 42, image height in pixels
- `NUM_IMG`, 3, number of images stacked in the ROM, image k at base k*IMG_W*IMG_H
- `ADDR_W`, 14, ROM address width; must satisfy NUM_IMG*IMG_W*IMG_H <= 2^ADDR_W
- `DATA_W`, 24, pixel colour width (RGB888)
- `TRANSP`, 24'hFF00FF, colour key treated as transparent
- `BLINK_FRAMES`, 16, frames per blink phase, >= 1
- `vga_clk` in 1, pixel clock, sole clock
- `reset` in 1, synchronous, active-high
- `x_pos` in 10, current screen column
- `y_pos` in 10, current screen row
- `origin_x` in 10, sprite top-left column
- `origin_y` in 10, sprite top-left row
- `img_sel` in 2 (clog2(NUM_IMG)), requested image index
- `img_sel_valid` in 1, one-cycle strobe loading `img_sel` into the pending register
- `frame_start` in 1, one-cycle strobe at the first pixel of a frame
- `scale2x` in 1, draw each source pixel as a 2x2 block
- `blink_en` in 1, enable periodic hiding
- `rom_addr` out ADDR_W, address to external sprite ROM (1-cycle registered read)
- `rom_q` in DATA_W, ROM data, valid the cycle after `rom_addr`
- `out_data` out DATA_W, pixel colour, 0 when not hit
- `out_hit` out 1, sprite is opaque at this pixel

## Operation
- Image select: an `img_sel_valid` with `img_sel < NUM_IMG` loads `pending`. Out-of-range values are ignored and `pending` is unchanged. `frame_start` copies `pending` to `active`. If both strobes occur in the same cycle, the new valid `img_sel` goes straight to `active` and `pending`.
- Stage 1: `rx = x_pos - origin_x` and `ry = y_pos - origin_y`, computed 11-bit with borrow. The pixel is inside when there is no borrow and `rx < W_eff`, `ry < H_eff`. W_eff/H_eff are IMG_W/IMG_H, or double those when `scale2x=1`. In scale mode, `rx` and `ry` are shifted right by 1. The stage registers `inside`, the source coordinates, and `active`.
- Stage 2: `rom_addr <= active*IMG_W*IMG_H + sy*IMG_W + sx`, using constant multipliers and ADDR_W-bit unsigned arithmetic. If not inside, `rom_addr <= 0`. `inside` is carried forward.
- Stage 3: `out_hit <= inside_d2 & visible & (rom_q != TRANSP)`. `out_data <= out_hit_next ? rom_q : 0`.
- Blink: the counter `bcnt` (clog2(BLINK_FRAMES) bits) increments on each `frame_start` while `blink_en=1`. When it reaches BLINK_FRAMES-1 it wraps to 0 and `visible` toggles. When `blink_en=0`, `bcnt` is 0 and `visible` is 1.
- Changes to `blink_en`, `scale2x` and `origin_*` take effect on the next sampled pixel. They are not frame-latched.

## Timing
- Latency from `x_pos`/`y_pos` to `out_data`/`out_hit` is 3 cycles, fully pipelined at 1 pixel per cycle, with no stalls.
- Reset state: `out_data=0`, `out_hit=0`, `rom_addr=0`, `active=0`, `pending=0`, `bcnt=0`, `visible=1`, and all pipeline `inside` bits 0.
- Reset mid-frame clears the pipeline. The first valid output appears 3 cycles after `reset` deasserts.
- `frame_start` affects pixels sampled in its own cycle onward. The pixel sampled in the same cycle as `frame_start` already uses the new `active`.
- Edge cases:
  - The sprite clipped at the right or bottom screen edge needs no special handling.
  - `origin_x > x_pos` wraps negative and is treated as outside.
  - With `x_pos = origin_x + W_eff - 1`, the pixel is inside.
  - With `x_pos = origin_x + W_eff`, the pixel is outside.

## Test plan
- Reset, origin (100,50), img 0, ROM word = address. Scan (100,50) gives `rom_addr=0` on cycle 2 and `out_data=0`, `out_hit=1` on cycle 3. Scan (191,91) gives address 3863.
- `img_sel=2` strobe mid-frame does not change addresses until `frame_start`. After `frame_start`, (100,50) gives address 7728. `img_sel=3` with NUM_IMG=3 is ignored.
- `scale2x=1`, origin (0,0): (1,1) and (0,0) both give address 0. (183,83) gives 3863. (184,0) gives `out_hit=0`, `out_data=0`.
- ROM returns 24'hFF00FF at an inside pixel, giving `out_hit=0` and `out_data=0`. An adjacent pixel with 24'h123456 gives `out_hit=1`.
- `blink_en=1`, BLINK_FRAMES=16: `out_hit` is suppressed after the 16th `frame_start` and restored after the 32nd. Dropping `blink_en` restores visibility immediately.
- Assert `reset` with three inside pixels in flight: outputs are 0 for 3 cycles after release, and `active` returns to 0.
